hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Next-generation pipeline hazard controller for the 5-stage MIPS core.
- Handles the existing cases: load-use bubble, jump flush, branch redirect.
- Adds a sequential scoreboard for one in-flight multi-cycle op (mul/div) with programmable latency, and a data-memory wait freeze.
- Drives IF/ID/EX write-enables and flushes; sits beside the ID stage and takes inputs from ID, EX and the data-memory interface.

Parameters:
- REG_W, 5, register-index width (2**REG_W architectural registers; index 0 is hardwired zero).
- LAT_W, 5, width of the multi-cycle latency field; maximum latency is 2**LAT_W-1 cycles.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- id_rs  in  REG_W  ID source register 1
- id_rt  in  REG_W  ID source register 2
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_jump  in  1  J/JAL/JR decoded in ID
- id_mc_start  in  1  ID instruction is a multi-cycle op
- id_mc_dst  in  REG_W  destination of that op
- id_mc_lat  in  LAT_W  result latency in cycles after issue
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  REG_W  load destination in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_wait  in  1  data memory not ready
- if_write  out  1  PC / IF-ID register enable
- id_write  out  1  ID-EX register enable
- id_flush  out  1  clear IF-ID (bubble into ID)
- ex_flush  out  1  clear ID-EX (bubble into EX)
- ex_hold  out  1  hold EX-MEM and MEM-WB
- mc_busy  out  1  scoreboard entry pending

Behaviour:
- Outputs are combinational from inputs and registered state.
- During reset: pending=0, cnt=0, dst=0. With no inputs asserted the outputs are if_write=1, id_write=1, all flush/hold=0, mc_busy=0.
- A source match requires the use bit set, a register index != 0 and equal indices.
- load_hz: ex_mem_read and (rs or rt) matches ex_rt.
- mc_raw: pending and (rs or rt) matches dst.
- mc_struct: id_mc_start and pending.
- Priority, highest first:
  1. mem_wait → if_write=0, id_write=0, ex_hold=1, no flushes (full freeze).
  2. ex_branch_taken → if_write=1, id_write=0, id_flush=1, ex_flush=1 (wrong path squashed; overrides any stall).
  3. load_hz, mc_raw or mc_struct → if_write=0, id_write=0, ex_flush=1, id_flush=0.
  4. id_jump → if_write=1, id_write=1, id_flush=1.
  5. Otherwise all enables are 1 and all flushes are 0.
- Issue: accept = id_mc_start and the priority case is 4 or 5.
  - On accept: dst←id_mc_dst, cnt←id_mc_lat, pending←(id_mc_lat!=0 and id_mc_dst!=0).
- Countdown: when pending and not accepting, cnt←cnt-1 every cycle, independent of mem_wait. When cnt==1, pending←0 at that edge.
- Result timing: a dependent instruction is released in the cycle after pending clears. Latency L therefore stalls a back-to-back consumer for exactly L cycles.
- mc_busy = pending.
- Reset asserted mid-operation drops the pending op immediately.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs stall_cnt (32) and flush_cnt (32).
  - stall_cnt increments once per cycle in which priority case 1 or 3 is active.
  - flush_cnt increments once per cycle in which id_flush=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and registers do not exist.

Decomposition:
- Package hazard_pkg holds:
  - REG_W and LAT_W defaults.
  - Localparam REG_ZERO=0.
  - A 3-bit priority-case encoding (FREEZE, REDIRECT, STALL, JFLUSH, RUN) used internally and by the bench's checker.
- Sub-module mc_scoreboard contains pending/dst/cnt, accept loading, countdown and the match logic. Inputs: accept, issue fields, rs/rt plus use bits. Outputs: mc_raw, pending.
- hazard_unit_mc contains the priority mux and the perf counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_use_rs=1 → if_write=0, id_write=0, ex_flush=1 for 1 cycle. Repeat with ex_rt=0 → no stall.
- Multi-cycle RAW: issue mc op with dst=9, lat=4; next instruction reads rt=9 → stalled exactly 4 cycles, mc_busy high 4 cycles, released in cycle 5.
- Structural: second id_mc_start while pending with cnt=3 → stalled 3 cycles, then accepted; a second entry with dst=10, lat=2 loads correctly.
- Branch over stall: load_hz and ex_branch_taken in the same cycle → id_flush=1, ex_flush=1, if_write=1. mc op in ID with ex_branch_taken → not accepted, mc_busy stays 0.
- Freeze: mem_wait=1 for 3 cycles during mc countdown at lat=5 → if_write=0, id_write=0, ex_hold=1, no flushes; countdown continues and mc_busy drops 5 cycles after issue.
- Reset mid-op: assert reset with pending and cnt=6 → mc_busy=0 immediately; after release, outputs return to if_write=1, id_write=1. With HAZARD_PERF_EN, stall_cnt=0 after reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared widths, the zero-register index and the priority-case encoding for the hazard unit.
package hazard_pkg;
    localparam int REG_W_DEF = 5;
    localparam int LAT_W_DEF = 5;
    localparam int REG_ZERO  = 0;

    typedef enum logic [2:0] {
        PC_FREEZE   = 3'd0,
        PC_REDIRECT = 3'd1,
        PC_STALL    = 3'd2,
        PC_JFLUSH   = 3'd3,
        PC_RUN      = 3'd4
    } prio_e;
endpackage

// File: rtl/mc_scoreboard.sv
// Single-entry scoreboard for one in-flight multi-cycle op: holds its destination,
// counts down its latency and flags RAW hits from the ID sources.
module mc_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [REG_W-1:0] mc_dst,
    input  logic [LAT_W-1:0] mc_lat,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    output logic             mc_raw,
    output logic             pending
);
    logic [REG_W-1:0] dst;
    logic [LAT_W-1:0] cnt;
    logic             rs_hit;
    logic             rt_hit;

    // Zero latency or a write to r0 produces nothing a consumer can wait on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            cnt     <= '0;
            dst     <= '0;
        end else if (accept) begin
            dst     <= mc_dst;
            cnt     <= mc_lat;
            pending <= (mc_lat != '0) && (mc_dst != REG_W'(REG_ZERO));
        end else if (pending) begin
            cnt <= cnt - LAT_W'(1);
            if (cnt == LAT_W'(1)) pending <= 1'b0;
        end
    end

    assign rs_hit = use_rs && (rs != REG_W'(REG_ZERO)) && (rs == dst);
    assign rt_hit = use_rt && (rt != REG_W'(REG_ZERO)) && (rt == dst);
    assign mc_raw = pending && (rs_hit || rt_hit);
endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: freeze/redirect/stall/jump-flush priority mux plus mc scoreboard.
// Optional HAZARD_PERF_EN adds saturating stall and flush event counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jump,
    input  logic             id_mc_start,
    input  logic [REG_W-1:0] id_mc_dst,
    input  logic [LAT_W-1:0] id_mc_lat,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             if_write,
    output logic             id_write,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             ex_hold,
    output logic             mc_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);
    logic  load_hz;
    logic  mc_raw;
    logic  mc_struct;
    logic  pending;
    logic  accept;
    prio_e prio;

    assign load_hz = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                     ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    assign mc_struct = id_mc_start && pending;

    always_comb begin
        prio = PC_RUN;
        if (mem_wait)                            prio = PC_FREEZE;
        else if (ex_branch_taken)                prio = PC_REDIRECT;
        else if (load_hz || mc_raw || mc_struct) prio = PC_STALL;
        else if (id_jump)                        prio = PC_JFLUSH;
    end

    always_comb begin
        if_write = 1'b1;
        id_write = 1'b1;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        ex_hold  = 1'b0;
        case (prio)
            PC_FREEZE: begin
                if_write = 1'b0;
                id_write = 1'b0;
                ex_hold  = 1'b1;
            end
            PC_REDIRECT: begin
                id_write = 1'b0;
                id_flush = 1'b1;
                ex_flush = 1'b1;
            end
            PC_STALL: begin
                if_write = 1'b0;
                id_write = 1'b0;
                ex_flush = 1'b1;
            end
            PC_JFLUSH: id_flush = 1'b1;
            default: ;
        endcase
    end

    // An mc op only issues when its ID slot actually advances.
    assign accept  = id_mc_start && ((prio == PC_JFLUSH) || (prio == PC_RUN));
    assign mc_busy = pending;

    mc_scoreboard #(.REG_W(REG_W), .LAT_W(LAT_W)) u_sb (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .mc_dst  (id_mc_dst),
        .mc_lat  (id_mc_lat),
        .rs      (id_rs),
        .rt      (id_rt),
        .use_rs  (id_use_rs),
        .use_rt  (id_use_rt),
        .mc_raw  (mc_raw),
        .pending (pending)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (((prio == PC_FREEZE) || (prio == PC_STALL)) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (id_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: per-cycle expected outputs queued at drive time, compared at negedge.
module tb_hazard_unit_mc;
    import hazard_pkg::*;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       jump;
        logic       mc_start;
        logic [4:0] mc_dst;
        logic [4:0] mc_lat;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       mw;
    } stim_t;

    localparam logic [4:0] O_RUN = 5'b11000;
    localparam logic [4:0] O_FRZ = 5'b00001;
    localparam logic [4:0] O_RED = 5'b10110;
    localparam logic [4:0] O_STL = 5'b00010;
    localparam logic [4:0] O_JF  = 5'b11100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_mc_dst = '0, id_mc_lat = '0, ex_rt = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_jump = 1'b0, id_mc_start = 1'b0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_wait = 1'b0;
    logic       if_write, id_write, id_flush, ex_flush, ex_hold, mc_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    logic [5:0] outs;
    logic [5:0] exp_q[$];
    int         n_run = 0;
    int         n_fail = 0;

    assign outs = {if_write, id_write, id_flush, ex_flush, ex_hold, mc_busy};

    always #5 clk = ~clk;

    hazard_unit_mc dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jump(id_jump), .id_mc_start(id_mc_start), .id_mc_dst(id_mc_dst), .id_mc_lat(id_mc_lat),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_wait(mem_wait),
        .if_write(if_write), .id_write(id_write), .id_flush(id_flush), .ex_flush(ex_flush),
        .ex_hold(ex_hold), .mc_busy(mc_busy)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic apply(input stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
        id_jump = s.jump; id_mc_start = s.mc_start; id_mc_dst = s.mc_dst; id_mc_lat = s.mc_lat;
        ex_mem_read = s.mem_read; ex_rt = s.ex_rt; ex_branch_taken = s.br; mem_wait = s.mw;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        apply('0);
        exp_q.push_back({O_RUN, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL reset_state got %b exp %b", outs, e);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t st[$]; logic [5:0] ex[$]; logic [5:0] e;
        st.push_back('{rs:5'd8, use_rs:1'b1, mem_read:1'b1, ex_rt:5'd8, default:'0}); ex.push_back({O_STL, 1'b0});
        st.push_back('0);                                                             ex.push_back({O_RUN, 1'b0});
        st.push_back('{rs:5'd0, use_rs:1'b1, mem_read:1'b1, ex_rt:5'd0, default:'0}); ex.push_back({O_RUN, 1'b0});
        st.push_back('{rt:5'd8, use_rt:1'b0, mem_read:1'b1, ex_rt:5'd8, default:'0}); ex.push_back({O_RUN, 1'b0});
        st.push_back('{rt:5'd8, use_rt:1'b1, mem_read:1'b1, ex_rt:5'd8, default:'0}); ex.push_back({O_STL, 1'b0});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front(); n_run++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL load_use cyc %0d got %b exp %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mc_raw();
        stim_t st[$]; logic [5:0] ex[$]; logic [5:0] e;
        st.push_back('{mc_start:1'b1, mc_dst:5'd9, mc_lat:5'd4, default:'0}); ex.push_back({O_RUN, 1'b0});
        for (int k = 0; k < 4; k++) begin
            st.push_back('{rt:5'd9, use_rt:1'b1, default:'0}); ex.push_back({O_STL, 1'b1});
        end
        st.push_back('{rt:5'd9, use_rt:1'b1, default:'0});                     ex.push_back({O_RUN, 1'b0});
        st.push_back('{mc_start:1'b1, mc_dst:5'd0, mc_lat:5'd3, default:'0}); ex.push_back({O_RUN, 1'b0});
        st.push_back('0);                                                      ex.push_back({O_RUN, 1'b0});
        st.push_back('{mc_start:1'b1, mc_dst:5'd5, mc_lat:5'd0, default:'0}); ex.push_back({O_RUN, 1'b0});
        st.push_back('{rs:5'd5, use_rs:1'b1, default:'0});                     ex.push_back({O_RUN, 1'b0});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front(); n_run++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL mc_raw cyc %0d got %b exp %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_struct();
        stim_t st[$]; logic [5:0] ex[$]; logic [5:0] e;
        st.push_back('{mc_start:1'b1, mc_dst:5'd7, mc_lat:5'd3, default:'0}); ex.push_back({O_RUN, 1'b0});
        for (int k = 0; k < 3; k++) begin
            st.push_back('{mc_start:1'b1, mc_dst:5'd10, mc_lat:5'd2, default:'0}); ex.push_back({O_STL, 1'b1});
        end
        st.push_back('{mc_start:1'b1, mc_dst:5'd10, mc_lat:5'd2, default:'0}); ex.push_back({O_RUN, 1'b0});
        st.push_back('{rs:5'd10, use_rs:1'b1, default:'0});                     ex.push_back({O_STL, 1'b1});
        st.push_back('{rs:5'd10, use_rs:1'b1, default:'0});                     ex.push_back({O_STL, 1'b1});
        st.push_back('{rs:5'd10, use_rs:1'b1, default:'0});                     ex.push_back({O_RUN, 1'b0});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front(); n_run++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL struct cyc %0d got %b exp %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$]; logic [5:0] ex[$]; logic [5:0] e;
        st.push_back('{mc_start:1'b1, mc_dst:5'd4, mc_lat:5'd1, default:'0});                   ex.push_back({O_RUN, 1'b0});
        st.push_back('{rs:5'd4, use_rs:1'b1, default:'0});                                       ex.push_back({O_STL, 1'b1});
        st.push_back('{rs:5'd4, use_rs:1'b1, mc_start:1'b1, mc_dst:5'd4, mc_lat:5'd2, default:'0}); ex.push_back({O_RUN, 1'b0});
        st.push_back('{rt:5'd4, use_rt:1'b1, default:'0});                                       ex.push_back({O_STL, 1'b1});
        st.push_back('{rt:5'd4, use_rt:1'b1, default:'0});                                       ex.push_back({O_STL, 1'b1});
        st.push_back('{rt:5'd4, use_rt:1'b1, default:'0});                                       ex.push_back({O_RUN, 1'b0});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front(); n_run++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d got %b exp %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t st[$]; logic [5:0] ex[$]; logic [5:0] e;
        st.push_back('{rs:5'd8, use_rs:1'b1, mem_read:1'b1, ex_rt:5'd8, br:1'b1, default:'0}); ex.push_back({O_RED, 1'b0});
        st.push_back('{mc_start:1'b1, mc_dst:5'd9, mc_lat:5'd4, br:1'b1, default:'0});        ex.push_back({O_RED, 1'b0});
        st.push_back('{rs:5'd9, use_rs:1'b1, default:'0});                                     ex.push_back({O_RUN, 1'b0});
        st.push_back('{jump:1'b1, default:'0});                                                ex.push_back({O_JF, 1'b0});
        st.push_back('{jump:1'b1, rs:5'd3, use_rs:1'b1, mem_read:1'b1, ex_rt:5'd3, default:'0}); ex.push_back({O_STL, 1'b0});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front(); n_run++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL branch cyc %0d got %b exp %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_freeze();
        stim_t st[$]; logic [5:0] ex[$]; logic [5:0] e;
        st.push_back('{mc_start:1'b1, mc_dst:5'd12, mc_lat:5'd5, default:'0}); ex.push_back({O_RUN, 1'b0});
        for (int k = 0; k < 3; k++) begin
            st.push_back('{mw:1'b1, default:'0}); ex.push_back({O_FRZ, 1'b1});
        end
        st.push_back('0);                                                       ex.push_back({O_RUN, 1'b1});
        st.push_back('0);                                                       ex.push_back({O_RUN, 1'b1});
        st.push_back('0);                                                       ex.push_back({O_RUN, 1'b0});
        st.push_back('{mw:1'b1, br:1'b1, default:'0});                          ex.push_back({O_FRZ, 1'b0});
        st.push_back('{mw:1'b1, mc_start:1'b1, mc_dst:5'd3, mc_lat:5'd2, default:'0}); ex.push_back({O_FRZ, 1'b0});
        st.push_back('{rs:5'd3, use_rs:1'b1, default:'0});                      ex.push_back({O_RUN, 1'b0});
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front(); n_run++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL freeze cyc %0d got %b exp %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e;
        apply('{mc_start:1'b1, mc_dst:5'd6, mc_lat:5'd9, default:'0});
        @(posedge clk); #1;
        apply('0);
        repeat (3) begin @(posedge clk); #1; end
        exp_q.push_back({O_RUN, 1'b1});
        @(negedge clk);
        e = exp_q.pop_front(); n_run++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_pre got %b exp %b", outs, e);
        end
        #2 reset = 1'b0;
        exp_q.push_back({O_RUN, 1'b0});
        #1;
        e = exp_q.pop_front(); n_run++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_drop got %b exp %b", outs, e);
        end
        @(posedge clk); #1 reset = 1'b1;
        apply('{rs:5'd6, use_rs:1'b1, default:'0});
        exp_q.push_back({O_RUN, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front(); n_run++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_after got %b exp %b", outs, e);
        end
`ifdef HAZARD_PERF_EN
        n_run++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset got stall %0d flush %0d exp 0 0", stall_cnt, flush_cnt);
        end
        @(posedge clk); #1;
        apply('{rs:5'd2, use_rs:1'b1, mem_read:1'b1, ex_rt:5'd2, default:'0});
        @(posedge clk); #1;
        apply('{jump:1'b1, default:'0});
        @(posedge clk); #1;
        apply('0);
        @(negedge clk);
        n_run++;
        if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_count got stall %0d flush %0d exp 1 1", stall_cnt, flush_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mc_raw();
        test_struct();
        test_back_to_back();
        test_branch();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
